parametric_rr_mux: RTL and testbench
====================================

Name: parametric_rr_mux

Overview:
- N-to-1 stream multiplexer; inverse of the parametric demux. Collects NUM_INPUTS valid/ready source streams onto one output stream.
- Round-robin arbitration with packet lock (LAST) and a registered output stage.
- Emits the index of the source that produced each beat, so a downstream demux can route replies back.
- Sits between per-channel producers and a shared datapath/link.

Parameters:
DATA_WIDTH, 16, width of every data bus
NUM_INPUTS, 8, number of source streams (>=2)
SEL_WIDTH, $clog2(NUM_INPUTS), width of source index (derived, not overridden)

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous active-high reset
BUS_IN  input  DATA_WIDTH x NUM_INPUTS (unpacked array)  per-source data
VALID_IN  input  NUM_INPUTS  per-source valid
LAST_IN  input  NUM_INPUTS  per-source end-of-packet marker
READY_OUT  output  NUM_INPUTS  per-source ready (combinational)
BUS_OUT  output  DATA_WIDTH  registered output data
VALID_OUT  output  1  registered output valid
LAST_OUT  output  1  registered output last
SEL_OUT  output  SEL_WIDTH  registered index of source of current beat
READY_IN  input  1  downstream ready

Behaviour:
- Reset (async assert, sync deassert by upstream): VALID_OUT=0, BUS_OUT=0, LAST_OUT=0, SEL_OUT=0, lock state IDLE, last-grant pointer=NUM_INPUTS-1 (input 0 has top priority after reset).
- Transfer rules:
  - Input beat transfers on VALID_IN[i] && READY_OUT[i].
  - Output beat transfers on VALID_OUT && READY_IN.
- Output stage is "free" when !VALID_OUT || READY_IN.
- READY_OUT[i] = (grant==i) && free. At most one READY_OUT bit is high in any cycle. READY_OUT is 0 while RST is high.
- Grant, state IDLE: first i with VALID_IN[i]=1, searching from pointer+1 upward with wrap-around modulo NUM_INPUTS. No valid input means no grant.
- Grant, state LOCKED(k): grant=k regardless of other valids. READY_OUT[k] still requires free.
- On an accepted input beat from i:
  - BUS_OUT<=BUS_IN[i], LAST_OUT<=LAST_IN[i], SEL_OUT<=i, VALID_OUT<=1.
  - If LAST_IN[i]=0: state<=LOCKED(i).
  - If LAST_IN[i]=1: state<=IDLE and pointer<=i.
- Output consumed with no new input accepted: VALID_OUT<=0. BUS_OUT, SEL_OUT and LAST_OUT hold their values.
- Latency: 1 cycle from input acceptance to VALID_OUT. Full throughput of 1 beat/cycle while READY_IN=1, including back-to-back packets from different sources.
- Backpressure: READY_IN=0 with VALID_OUT=1 means all READY_OUT=0 and the output registers hold stable.
- Single-beat packet (LAST_IN=1 on first beat) never locks.
- Source in LOCKED deasserts VALID_IN mid-packet: the lock is held and no other source is granted (no interleaving).
- Arbitration is re-evaluated every cycle in IDLE. A source may drop VALID before being granted; this is a protocol violation upstream, and the block simply grants another source.
- Reset mid-packet: the lock is cleared and any partial packet is discarded from the output register.

Decomposition:
- Shared package parametric_mux_pkg: state enum (MUX_IDLE, MUX_LOCKED) and a helper function computing the next round-robin index (pointer, request vector) -> index + found flag.
- One natural sub-module: rr_arbiter.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational, reusable elsewhere.
- Top holds lock FSM, pointer and output register.

Test Plan:
- Reset, then VALID_IN=8'h01, BUS_IN[0]=16'hA5A5, LAST_IN[0]=1, READY_IN=1 -> next cycle BUS_OUT=16'hA5A5, SEL_OUT=0, LAST_OUT=1, VALID_OUT=1; READY_OUT=8'h01 in the accept cycle.
- All 8 inputs valid with single-beat packets (BUS_IN[i]=16'h1000+i) held for 16 cycles, READY_IN=1 -> SEL_OUT sequence 0,1,...,7,0,...,7 at one beat/cycle.
- Source 3 sends a 4-beat packet (LAST on beat 4) while source 5 is valid throughout -> beats from 3 are contiguous with SEL_OUT=3; SEL_OUT=5 first appears in the cycle after LAST_OUT=1 from source 3.
- Inputs 2 and 6 valid, READY_IN=0 for 5 cycles after the first accept -> BUS_OUT, SEL_OUT and VALID_OUT are stable and READY_OUT=0. On READY_IN=1 the next beat is accepted with no beat lost or duplicated, checked via scoreboard over 200 random beats.
- Source 1 is locked mid-packet and VALID_IN[1] drops for 3 cycles while source 4 is valid -> no grant to 4 until source 1's LAST beat is accepted.
- RST asserted asynchronously mid-packet (between clock edges) -> VALID_OUT=0 immediately. After release, input 0 has priority (inputs 0 and 7 both valid: SEL_OUT=0 first).

Source files
------------

// File: rtl/parametric_mux_pkg.sv
// Shared types and the round-robin search helper used by the stream mux.
package parametric_mux_pkg;

  // Packet-lock state of the mux: free to arbitrate, or held by one source
  typedef enum logic {
    MUX_IDLE   = 1'b0,
    MUX_LOCKED = 1'b1
  } mux_state_t;

  // Largest request vector the helper can search; index width to match
  localparam int RR_MAX_INPUTS = 64;
  localparam int RR_IDX_WIDTH  = 6;

  // Result of a round-robin search: whether anything requested, and who
  typedef struct packed {
    logic                    found;
    logic [RR_IDX_WIDTH-1:0] index;
  } rr_pick_t;

  // First requesting index strictly after 'pointer', wrapping modulo 'num'.
  // The pointer itself is visited last, so the previous winner has lowest
  // priority. Loop bound is constant; the live range is limited by 'num'.
  function automatic rr_pick_t rr_next_index(
    input int                       pointer,
    input logic [RR_MAX_INPUTS-1:0] req,
    input int                       num
  );
    rr_pick_t pick;
    int       cand;
    pick = '0;
    cand = 0;
    for (int off = 1; off <= RR_MAX_INPUTS; off++) begin
      if (off <= num) begin
        cand = pointer + off;
        if (cand >= num) begin
          cand = cand - num;
        end
        if (!pick.found && req[cand[RR_IDX_WIDTH-1:0]]) begin
          pick.found = 1'b1;
          pick.index = cand[RR_IDX_WIDTH-1:0];
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter: searches the request vector
// starting just after the pointer and returns a one-hot grant plus the
// encoded winner. NUM_REQ must not exceed the package search limit.
module rr_arbiter
  import parametric_mux_pkg::*;
#(
  parameter int NUM_REQ   = 8,
  parameter int SEL_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [SEL_WIDTH-1:0] pointer,
  output logic [NUM_REQ-1:0]   grant,
  output logic [SEL_WIDTH-1:0] index,
  output logic                 found
);

  logic [RR_MAX_INPUTS-1:0] req_ext;
  rr_pick_t                 pick;

  // Widen the request vector to the helper's size and run the search
  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    pick                   = rr_next_index(int'(pointer), req_ext, NUM_REQ);
  end

  assign found = pick.found;
  assign index = pick.index[SEL_WIDTH-1:0];

  // Decode the winner into a one-hot grant, all zero when nobody requests
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = pick.found && (pick.index == RR_IDX_WIDTH'(gi));
    end
  endgenerate

endmodule

// File: rtl/parametric_rr_mux.sv
// N-to-1 valid/ready stream mux. Round-robin arbitration between packets,
// a packet lock from first beat to LAST so packets never interleave, and a
// single registered output stage that also reports which source each beat
// came from (SEL_OUT) for routing replies back through a demux.
module parametric_rr_mux
  import parametric_mux_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_INPUTS = 8,
  localparam int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] BUS_IN [NUM_INPUTS],
  input  logic [NUM_INPUTS-1:0] VALID_IN,
  input  logic [NUM_INPUTS-1:0] LAST_IN,
  output logic [NUM_INPUTS-1:0] READY_OUT,
  output logic [DATA_WIDTH-1:0] BUS_OUT,
  output logic                  VALID_OUT,
  output logic                  LAST_OUT,
  output logic [SEL_WIDTH-1:0]  SEL_OUT,
  input  logic                  READY_IN
);

  // Lock FSM and round-robin pointer
  mux_state_t           state_reg, state_next;
  logic [SEL_WIDTH-1:0] lock_idx_reg, lock_idx_next;
  logic [SEL_WIDTH-1:0] ptr_reg, ptr_next;

  // Output register stage
  logic [DATA_WIDTH-1:0] data_reg, data_next;
  logic                  valid_reg, valid_next;
  logic                  last_reg, last_next;
  logic [SEL_WIDTH-1:0]  sel_reg, sel_next;

  // Arbitration results
  logic [NUM_INPUTS-1:0] arb_grant;
  logic [SEL_WIDTH-1:0]  arb_index;
  logic                  arb_found;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic                  grant_valid;
  logic                  stage_free;
  logic                  accept;

  rr_arbiter #(
    .NUM_REQ   (NUM_INPUTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_arbiter (
    .req     (VALID_IN),
    .pointer (ptr_reg),
    .grant   (arb_grant),
    .index   (arb_index),
    .found   (arb_found)
  );

  // Pick the granted source: the locked owner, else the round-robin winner.
  // A locked owner stays granted even while its VALID is low.
  always_comb begin
    stage_free = !valid_reg || READY_IN;
    if (state_reg == MUX_LOCKED) begin
      grant_idx   = lock_idx_reg;
      grant_valid = 1'b1;
    end else begin
      grant_idx   = arb_index;
      grant_valid = arb_found;
    end
    accept = stage_free && grant_valid && VALID_IN[grant_idx];
  end

  // Per-source ready: only the granted source, only when the stage can take
  // a beat, and forced low while reset is held
  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_ready
      assign READY_OUT[gi] = !RST && stage_free &&
                             ((state_reg == MUX_LOCKED) ?
                              (lock_idx_reg == SEL_WIDTH'(gi)) : arb_grant[gi]);
    end
  endgenerate

  // Next-state logic for lock FSM, pointer and output register
  always_comb begin
    state_next    = state_reg;
    lock_idx_next = lock_idx_reg;
    ptr_next      = ptr_reg;
    data_next     = data_reg;
    valid_next    = valid_reg;
    last_next     = last_reg;
    sel_next      = sel_reg;

    if (accept) begin
      data_next  = BUS_IN[grant_idx];
      last_next  = LAST_IN[grant_idx];
      sel_next   = grant_idx;
      valid_next = 1'b1;
      if (LAST_IN[grant_idx]) begin
        // Packet done: release the lock and move priority past this source
        state_next = MUX_IDLE;
        ptr_next   = grant_idx;
      end else begin
        state_next    = MUX_LOCKED;
        lock_idx_next = grant_idx;
      end
    end else if (valid_reg && READY_IN) begin
      // Beat drained with nothing behind it; data/sel/last keep their value
      valid_next = 1'b0;
    end
  end

  // State register; reset drops any partial packet and gives input 0 priority
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= MUX_IDLE;
      lock_idx_reg <= '0;
      ptr_reg      <= SEL_WIDTH'(NUM_INPUTS - 1);
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      last_reg     <= 1'b0;
      sel_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      lock_idx_reg <= lock_idx_next;
      ptr_reg      <= ptr_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      last_reg     <= last_next;
      sel_reg      <= sel_next;
    end
  end

  assign BUS_OUT   = data_reg;
  assign VALID_OUT = valid_reg;
  assign LAST_OUT  = last_reg;
  assign SEL_OUT   = sel_reg;

endmodule

// File: tb/tb_parametric_rr_mux.sv
// Bench for parametric_rr_mux: a cycle table from reset, directed sequences
// for lock/backpressure/reset corners, and an always-on scoreboard with a
// reference arbitration model sampled on the falling clock edge.
module tb_parametric_rr_mux;

  localparam int DW = 16;
  localparam int NI = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] bus_in [NI];
  logic [NI-1:0] valid_in;
  logic [NI-1:0] last_in;
  logic [NI-1:0] ready_out;
  logic [DW-1:0] bus_out;
  logic          valid_out;
  logic          last_out;
  logic [2:0]    sel_out;
  logic          ready_in;

  int n_cmp  = 0;
  int n_fail = 0;

  parametric_rr_mux #(
    .DATA_WIDTH (DW),
    .NUM_INPUTS (NI)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .BUS_IN    (bus_in),
    .VALID_IN  (valid_in),
    .LAST_IN   (last_in),
    .READY_OUT (ready_out),
    .BUS_OUT   (bus_out),
    .VALID_OUT (valid_out),
    .LAST_OUT  (last_out),
    .SEL_OUT   (sel_out),
    .READY_IN  (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard + reference model ----------------
  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [2:0]  sel;
  } beat_t;

  beat_t         exp_q[$];
  int            m_ptr    = NI - 1;
  logic          m_locked = 1'b0;
  int            m_lock   = 0;
  logic [NI-1:0] acc_seen = '0;
  int            popped   = 0;

  // One line per output transaction checked against the queue
  always @(negedge clk) begin : monitor
    beat_t         h;
    logic          fr;
    logic          found;
    logic [NI-1:0] er;
    logic [NI-1:0] acc;
    int            c;
    if (rst) begin
      exp_q.delete();
      m_ptr    = NI - 1;
      m_locked = 1'b0;
      m_lock   = 0;
      acc_seen = '0;
    end else begin
      chk("sb_valid", 32'(valid_out), 32'(exp_q.size() != 0));
      if (valid_out && exp_q.size() != 0) begin
        h = exp_q[0];
        chk("sb_data", 32'(bus_out), 32'(h.data));
        chk("sb_sel", 32'(sel_out), 32'(h.sel));
        chk("sb_last", 32'(last_out), 32'(h.last));
        if (ready_in) begin
          h = exp_q.pop_front();
          popped++;
          $display("out beat sel=%0d data=%h last=%0d", sel_out, bus_out, last_out);
        end
      end
      fr = !valid_out || ready_in;
      er = '0;
      if (m_locked) begin
        if (fr) er[m_lock[2:0]] = 1'b1;
      end else if (fr) begin
        found = 1'b0;
        for (int off = 1; off <= NI; off++) begin
          c = (m_ptr + off) % NI;
          if (!found && valid_in[c[2:0]]) begin
            found = 1'b1;
            er[c[2:0]] = 1'b1;
          end
        end
      end
      chk("ready_model", 32'(ready_out), 32'(er));
      acc = valid_in & ready_out;
      acc_seen = acc;
      for (int i = 0; i < NI; i++) begin
        if (acc[i]) begin
          h.data = bus_in[i];
          h.last = last_in[i];
          h.sel  = 3'(i);
          exp_q.push_back(h);
          if (last_in[i]) begin
            m_locked = 1'b0;
            m_ptr    = i;
          end else begin
            m_locked = 1'b1;
            m_lock   = i;
          end
        end
      end
    end
  end

  // ---------------- random stream generator ----------------
  int   gen_cnt [NI];
  int   gen_left[NI];
  logic gen_started[NI];

  task automatic gen_reset();
    for (int i = 0; i < NI; i++) begin
      gen_cnt[i]     = 0;
      gen_left[i]    = 0;
      gen_started[i] = 1'b0;
    end
  endtask

  // Called once per cycle at posedge+1; advances sources accepted last edge
  task automatic gen_cycle(input logic [NI-1:0] en, input logic rin);
    logic [3:0]  id;
    logic [11:0] cnt;
    for (int i = 0; i < NI; i++) begin
      if (acc_seen[i]) begin
        gen_cnt[i]++;
        gen_left[i]--;
        gen_started[i] = (gen_left[i] != 0);
      end
      if (!en[i]) begin
        valid_in[i] = 1'b0;
      end else if (valid_in[i] && !acc_seen[i]) begin
        if (gen_started[i] && $urandom_range(3) == 0) valid_in[i] = 1'b0;
      end else begin
        if (gen_left[i] == 0) gen_left[i] = $urandom_range(4, 1);
        valid_in[i] = ($urandom_range(1) == 1);
      end
      id  = 4'(i);
      cnt = 12'(gen_cnt[i]);
      bus_in[i]  = {id, cnt};
      last_in[i] = (gen_left[i] == 1);
    end
    ready_in = rin;
  endtask

  task automatic set_bus_default();
    for (int i = 0; i < NI; i++) bus_in[i] = 16'(32'h1000 + i);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    valid_in = '0;
    last_in  = '0;
    ready_in = 1'b1;
    gen_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic [7:0]  valid;
    logic [7:0]  last;
    logic        rin;
    logic [7:0]  exp_ready;
    logic        exp_vout;
    logic [2:0]  exp_sel;
    logic        exp_last;
    logic [15:0] exp_bus;
  } vec_t;

  initial begin : watchdog
    #(2_000_000);
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t tbl[13];
    tbl[0]  = '{8'h01, 8'hFF, 1'b1, 8'h01, 1'b0, 3'd0, 1'b0, 16'h0000};
    tbl[1]  = '{8'hFF, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd0, 1'b1, 16'h1000};
    tbl[2]  = '{8'hFF, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd1, 1'b1, 16'h1001};
    tbl[3]  = '{8'hA0, 8'hFF, 1'b1, 8'h20, 1'b1, 3'd2, 1'b1, 16'h1002};
    tbl[4]  = '{8'hA0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd5, 1'b1, 16'h1005};
    tbl[5]  = '{8'hA0, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd5, 1'b1, 16'h1005};
    tbl[6]  = '{8'hA0, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd5, 1'b1, 16'h1005};
    tbl[7]  = '{8'hA0, 8'h5F, 1'b1, 8'h20, 1'b1, 3'd7, 1'b1, 16'h1007};
    tbl[8]  = '{8'h81, 8'h5F, 1'b1, 8'h20, 1'b1, 3'd5, 1'b0, 16'h1005};
    tbl[9]  = '{8'hA1, 8'hFF, 1'b1, 8'h20, 1'b0, 3'd5, 1'b0, 16'h1005};
    tbl[10] = '{8'h81, 8'hFF, 1'b1, 8'h80, 1'b1, 3'd5, 1'b1, 16'h1005};
    tbl[11] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 3'd7, 1'b1, 16'h1007};
    tbl[12] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd7, 1'b1, 16'h1007};

    rst      = 1'b1;
    valid_in = '0;
    last_in  = '0;
    ready_in = 1'b0;
    for (int i = 0; i < NI; i++) bus_in[i] = '0;
    gen_reset();

    // --- table sequence from reset ---
    do_reset();
    set_bus_default();
    chk("reset_vout", 32'(valid_out), 32'd0);
    chk("reset_sel", 32'(sel_out), 32'd0);
    for (int r = 0; r < 13; r++) begin
      valid_in = tbl[r].valid;
      last_in  = tbl[r].last;
      ready_in = tbl[r].rin;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r), 32'(ready_out), 32'(tbl[r].exp_ready));
      chk($sformatf("tbl%0d_vout", r), 32'(valid_out), 32'(tbl[r].exp_vout));
      chk($sformatf("tbl%0d_sel", r), 32'(sel_out), 32'(tbl[r].exp_sel));
      chk($sformatf("tbl%0d_last", r), 32'(last_out), 32'(tbl[r].exp_last));
      chk($sformatf("tbl%0d_bus", r), 32'(bus_out), 32'(tbl[r].exp_bus));
      next_cycle();
    end

    // --- single beat A5A5 from source 0 ---
    do_reset();
    bus_in[0] = 16'hA5A5;
    valid_in  = 8'h01;
    last_in   = 8'hFF;
    ready_in  = 1'b1;
    @(negedge clk);
    chk("a5_ready", 32'(ready_out), 32'h01);
    next_cycle();
    valid_in = '0;
    @(negedge clk);
    chk("a5_bus", 32'(bus_out), 32'hA5A5);
    chk("a5_sel", 32'(sel_out), 32'd0);
    chk("a5_last", 32'(last_out), 32'd1);
    chk("a5_vout", 32'(valid_out), 32'd1);
    next_cycle();

    // --- all 8 valid, single-beat packets, full rate sweep ---
    do_reset();
    set_bus_default();
    valid_in = 8'hFF;
    last_in  = 8'hFF;
    ready_in = 1'b1;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        chk($sformatf("rr_sel%0d", c), 32'(sel_out), 32'((c - 1) % NI));
        chk($sformatf("rr_vout%0d", c), 32'(valid_out), 32'd1);
        chk($sformatf("rr_bus%0d", c), 32'(bus_out), 32'(32'h1000 + (c - 1) % NI));
      end
      next_cycle();
    end
    valid_in = '0;

    // --- 4-beat packet from source 3 while source 5 stays valid ---
    do_reset();
    set_bus_default();
    begin
      int          b;
      int          es[6];
      logic [15:0] eb[6];
      logic        el[6];
      logic        acc3;
      es = '{3, 3, 3, 3, 5, 5};
      eb = '{16'h3000, 16'h3001, 16'h3002, 16'h3003, 16'h1005, 16'h1005};
      el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      b = 0;
      bus_in[3] = 16'h3000;
      valid_in  = 8'h28;
      last_in   = 8'h20;
      ready_in  = 1'b1;
      for (int c = 0; c < 7; c++) begin
        @(negedge clk);
        if (c >= 1) begin
          chk($sformatf("pkt3_sel%0d", c), 32'(sel_out), 32'(es[c-1]));
          chk($sformatf("pkt3_last%0d", c), 32'(last_out), 32'(el[c-1]));
          chk($sformatf("pkt3_bus%0d", c), 32'(bus_out), 32'(eb[c-1]));
          chk($sformatf("pkt3_vout%0d", c), 32'(valid_out), 32'd1);
        end
        acc3 = valid_in[3] && ready_out[3];
        next_cycle();
        if (acc3) begin
          b++;
          if (b == 4) begin
            valid_in[3] = 1'b0;
          end else begin
            bus_in[3]  = 16'(32'h3000 + b);
            last_in[3] = (b == 3);
          end
        end
      end
      valid_in = '0;
    end

    // --- source 1 locked, its VALID drops for 3 cycles, source 4 waiting ---
    do_reset();
    set_bus_default();
    valid_in = 8'h02;
    last_in  = 8'h00;
    ready_in = 1'b1;
    @(negedge clk);
    chk("lock1_first_ready", 32'(ready_out), 32'h02);
    next_cycle();
    valid_in = 8'h10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("lock1_hold%0d", k), 32'(ready_out), 32'h02);
      next_cycle();
    end
    valid_in = 8'h12;
    last_in  = 8'h02;
    @(negedge clk);
    chk("lock1_last_ready", 32'(ready_out), 32'h02);
    next_cycle();
    valid_in = 8'h10;
    @(negedge clk);
    chk("lock1_release_ready", 32'(ready_out), 32'h10);
    chk("lock1_last_sel", 32'(sel_out), 32'd1);
    chk("lock1_last_flag", 32'(last_out), 32'd1);
    next_cycle();
    valid_in = '0;
    @(negedge clk);
    chk("lock1_then4_sel", 32'(sel_out), 32'd4);
    next_cycle();

    // --- backpressure on sources 2/6, then 200 random scoreboarded beats ---
    do_reset();
    begin
      int p0;
      int cyc;
      gen_left[2] = 1;
      gen_left[6] = 1;
      bus_in[2]   = 16'h2000;
      bus_in[6]   = 16'h6000;
      valid_in    = 8'h44;
      last_in     = 8'h44;
      ready_in    = 1'b1;
      @(negedge clk);
      chk("bp_first_ready", 32'(ready_out), 32'h04);
      next_cycle();
      for (int k = 0; k < 5; k++) begin
        gen_cycle(8'h44, 1'b0);
        @(negedge clk);
        chk($sformatf("bp_ready%0d", k), 32'(ready_out), 32'h00);
        chk($sformatf("bp_vout%0d", k), 32'(valid_out), 32'd1);
        chk($sformatf("bp_sel%0d", k), 32'(sel_out), 32'd2);
        chk($sformatf("bp_bus%0d", k), 32'(bus_out), 32'h2000);
        next_cycle();
      end
      p0  = popped;
      cyc = 0;
      while ((popped - p0) < 200 && cyc < 5000) begin
        gen_cycle(8'hFF, ($urandom_range(3) != 0));
        @(negedge clk);
        next_cycle();
        cyc++;
      end
      chk("rand_beats_done", 32'((popped - p0) >= 200), 32'd1);
      valid_in = '0;
      ready_in = 1'b1;
      @(negedge clk);
      next_cycle();
      @(negedge clk);
      chk("rand_drain_vout", 32'(valid_out), 32'd0);
      next_cycle();
    end

    // --- asynchronous reset mid-packet ---
    do_reset();
    set_bus_default();
    valid_in = 8'h81;
    last_in  = 8'h00;
    ready_in = 1'b1;
    @(negedge clk);
    chk("arst_pre_ready", 32'(ready_out), 32'h01);
    next_cycle();
    @(negedge clk);
    chk("arst_pre_vout", 32'(valid_out), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_vout", 32'(valid_out), 32'd0);
    chk("arst_ready", 32'(ready_out), 32'h00);
    chk("arst_bus", 32'(bus_out), 32'h0000);
    @(negedge clk);
    next_cycle();
    rst     = 1'b0;
    last_in = 8'hFF;
    @(negedge clk);
    chk("arst_post_ready", 32'(ready_out), 32'h01);
    next_cycle();
    @(negedge clk);
    chk("arst_post_sel", 32'(sel_out), 32'd0);
    chk("arst_post_vout", 32'(valid_out), 32'd1);
    chk("arst_post_bus", 32'(bus_out), 32'h1000);
    next_cycle();
    valid_in = '0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
